// File: rtl/fila_reader_if.sv
// Downstream byte stream bundle for fila_reader.
// master drives data/valid, slave drives ready.
interface fila_reader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fila_reader.sv
// Read-side controller for the 8-entry byte queue.
// Optional drain counter: define FILA_READER_COUNT_EN.
module fila_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              drain_en,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] q_data_in,
  input  logic [LEN_W-1:0]  q_len_in,
  input  logic              q_enqueue_mon,
  output logic              q_dequeue_out,
  fila_reader_if.master     out_bus,
  output logic              busy_out,
`ifdef FILA_READER_COUNT_EN
  output logic [CNT_W-1:0]  drain_count_out,
`endif
  output logic              flushing_out
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DEQ    = 3'd1;
  localparam logic [2:0] CAPT   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              flushing_q;
  logic              has_data;
  logic              start;

  // An enqueue in flight would mask our dequeue, so wait it out.
  always_comb begin
    has_data = (q_len_in != '0);
    start    = has_data && !q_enqueue_mon
               && (flush_in || drain_en);
  end

  // Main read sequencer; flush reads skip the output stage.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      flushing_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= DEQ;
            flushing_q <= flush_in;
          end else if (flushing_q
                       && (!flush_in || !has_data)) begin
            flushing_q <= 1'b0;
          end
        end
        DEQ: begin
          state <= CAPT;
        end
        CAPT: begin
          data_q <= q_data_in;
          state  <= SETTLE;
        end
        SETTLE: begin
          if (flushing_q) begin
            state      <= IDLE;
            flushing_q <= flush_in && has_data;
          end else begin
            state   <= OUT;
            valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (out_bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    q_dequeue_out     = (state == DEQ);
    busy_out          = (state != IDLE);
    flushing_out      = flushing_q;
    out_bus.out_data  = data_q;
    out_bus.out_valid = valid_q;
  end

`ifdef FILA_READER_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of every dequeue issued, flushes included.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == DEQ && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign drain_count_out = cnt_q;
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_fila_reader.sv
// Self-checking bench for fila_reader with a queue model.
// Build with FILA_READER_COUNT_EN to also check the counter.
module tb_fila_reader;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;
  localparam int CNT_W  = 2;

  logic             clk_10KHz = 1'b0;
  logic             reset     = 1'b1;
  logic             drain_en  = 1'b0;
  logic             flush_in  = 1'b0;
  logic             enq       = 1'b0;
  logic [7:0]       enq_data  = 8'h00;
  logic [7:0]       q_data    = 8'h00;
  logic [2:0]       q_len     = 3'd0;
  logic             deq;
  logic             busy;
  logic             flushing;
`ifdef FILA_READER_COUNT_EN
  logic [CNT_W-1:0] cnt;
`endif

  fila_reader_if #(.DATA_W(DATA_W)) ob ();

  fila_reader #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_10KHz      (clk_10KHz),
    .reset          (reset),
    .drain_en       (drain_en),
    .flush_in       (flush_in),
    .q_data_in      (q_data),
    .q_len_in       (q_len),
    .q_enqueue_mon  (enq),
    .q_dequeue_out  (deq),
    .out_bus        (ob),
    .busy_out       (busy),
`ifdef FILA_READER_COUNT_EN
    .drain_count_out(cnt),
`endif
    .flushing_out   (flushing)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  int   deq_total     = 0;
  int   deq_since_rst = 0;
  int   valid_cycles  = 0;
  int   b2b_err       = 0;
  int   deq_empty_err = 0;
  int   deq_enq_err   = 0;
  int   hold_err      = 0;
  logic hold_chk      = 1'b1;
  logic prev_deq      = 1'b0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  // Queue: registered pop data, length lags by one edge, enqueue wins.
  always @(posedge clk_10KHz) begin
    q_len <= 3'(mq.size());
    if (deq && prev_deq) b2b_err <= b2b_err + 1;
    if (deq && enq) deq_enq_err <= deq_enq_err + 1;
    if (deq && !enq && mq.size() == 0)
      deq_empty_err <= deq_empty_err + 1;
    if (enq) begin
      if (mq.size() < 8) mq.push_back(enq_data);
    end else if (deq && mq.size() > 0) begin
      q_data <= mq.pop_front();
    end
    if (deq) deq_total <= deq_total + 1;
    prev_deq <= deq;
  end

  // Consumer side: accepted bytes and stability under backpressure.
  always @(posedge clk_10KHz) begin
    if (ob.out_valid) valid_cycles <= valid_cycles + 1;
    if (ob.out_valid && ob.out_ready)
      acc_q.push_back(ob.out_data);
    if (hold_chk && pv && !pr) begin
      if (!ob.out_valid || ob.out_data !== pd)
        hold_err <= hold_err + 1;
    end
    pv <= ob.out_valid;
    pr <= ob.out_ready;
    pd <= ob.out_data;
  end

  always @(posedge clk_10KHz or posedge reset) begin
    if (reset) deq_since_rst <= 0;
    else if (deq) deq_since_rst <= deq_since_rst + 1;
  end

  task automatic enqueue_byte(input logic [7:0] b);
    enq_data = b;
    enq      = 1'b1;
    exp_q.push_back(b);
    @(negedge clk_10KHz);
    enq      = 1'b0;
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++)
      enqueue_byte(8'($urandom_range(0, 255)));
    repeat (2) @(negedge clk_10KHz);
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int k;
    k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(negedge clk_10KHz);
      k++;
    end
    vectors++;
    if (acc_q.size() < n) begin
      miscompares++;
      $display("FAIL accept_timeout got=%0d want=%0d",
               acc_q.size(), n);
    end
  endtask

  task automatic compare_stream(input string tag);
    vectors++;
    if (acc_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count got=%0d want=%0d",
               tag, acc_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_q.size()) begin
        vectors++;
        if (acc_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL %s_byte%0d got=%h want=%h",
                   tag, i, acc_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic fresh();
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_10KHz);
    vectors++;
    if ({ob.out_valid, deq, busy, flushing} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=0000",
               {ob.out_valid, deq, busy, flushing});
    end
    vectors++;
    if (ob.out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data got=%h want=00", ob.out_data);
    end
`ifdef FILA_READER_COUNT_EN
    vectors++;
    if (cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_count got=%0d want=0", cnt);
    end
`endif
    reset = 1'b0;
    @(negedge clk_10KHz);
  endtask

  task automatic test_single();
    int lat;
    int d0;
    fresh();
    ob.out_ready = 1'b1;
    drain_en = 1'b0;
    enqueue_byte(8'hA5);
    repeat (2) @(negedge clk_10KHz);
    d0 = deq_total;
    drain_en = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_10KHz);
      if (ob.out_valid) begin
        lat = i;
        break;
      end
    end
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL single_latency got=%0d want=4", lat);
    end
    vectors++;
    if (ob.out_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_data got=%h want=a5", ob.out_data);
    end
    repeat (3) @(negedge clk_10KHz);
    vectors++;
    if (deq_total - d0 != 1) begin
      miscompares++;
      $display("FAIL single_deqs got=%0d want=1", deq_total - d0);
    end
    vectors++;
    if (q_len !== 3'd0) begin
      miscompares++;
      $display("FAIL single_len got=%0d want=0", q_len);
    end
    compare_stream("single");
  endtask

  task automatic test_backpressure();
    int d0;
    int bad;
    int k;
    fresh();
    drain_en = 1'b0;
    ob.out_ready = 1'b0;
    enqueue_byte(8'h11);
    enqueue_byte(8'h22);
    repeat (2) @(negedge clk_10KHz);
    d0 = deq_total;
    drain_en = 1'b1;
    k = 0;
    while (!ob.out_valid && k < 20) begin
      @(negedge clk_10KHz);
      k++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_10KHz);
      if (!ob.out_valid || ob.out_data !== 8'h11) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold got=%0d bad cycles want=0", bad);
    end
    vectors++;
    if (deq_total - d0 != 1) begin
      miscompares++;
      $display("FAIL bp_deqs got=%0d want=1", deq_total - d0);
    end
    ob.out_ready = 1'b1;
    wait_accepts(2, 40);
    compare_stream("bp");
  endtask

  task automatic test_enq_collision();
    int d0;
    fresh();
    drain_en = 1'b0;
    ob.out_ready = 1'b1;
    preload(2);
    d0 = deq_total;
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++)
      enqueue_byte(8'($urandom_range(0, 255)));
    vectors++;
    if (deq_total != d0) begin
      miscompares++;
      $display("FAIL coll_deqs got=%0d want=0", deq_total - d0);
    end
    wait_accepts(5, 80);
    compare_stream("coll");
  endtask

  task automatic test_flush();
    int d0;
    int v0;
    int k;
    logic rose;
    logic fell;
    fresh();
    drain_en = 1'b0;
    ob.out_ready = 1'b1;
    preload(5);
    d0 = deq_total;
    v0 = valid_cycles;
    flush_in = 1'b1;
    rose = 1'b0;
    fell = 1'b0;
    k = 0;
    while (!fell && k < 100) begin
      @(negedge clk_10KHz);
      if (flushing) rose = 1'b1;
      else if (rose) fell = 1'b1;
      k++;
    end
    vectors++;
    if (!fell) begin
      miscompares++;
      $display("FAIL flush_done got=%b want=1", fell);
    end
    vectors++;
    if (deq_total - d0 != 5) begin
      miscompares++;
      $display("FAIL flush_deqs got=%0d want=5", deq_total - d0);
    end
    vectors++;
    if (valid_cycles != v0) begin
      miscompares++;
      $display("FAIL flush_valid got=%0d want=0",
               valid_cycles - v0);
    end
    vectors++;
    if (q_len !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_len got=%0d want=0", q_len);
    end
`ifdef FILA_READER_COUNT_EN
    begin
      int sat;
      int want;
      sat  = (1 << CNT_W) - 1;
      want = deq_since_rst > sat ? sat : deq_since_rst;
      vectors++;
      if (int'(cnt) != want) begin
        miscompares++;
        $display("FAIL count_sat got=%0d want=%0d", cnt, want);
      end
    end
`endif
    flush_in = 1'b0;
    repeat (2) @(negedge clk_10KHz);
    vectors++;
    if (acc_q.size() != 0) begin
      miscompares++;
      $display("FAIL flush_out got=%0d want=0", acc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int k;
    for (int r = 0; r < 6; r++) begin
      fresh();
      drain_en = 1'b0;
      n = $urandom_range(1, 7);
      preload(n);
      k = 0;
      while (acc_q.size() < n && k < 400) begin
        drain_en     = ($urandom_range(0, 3) != 0);
        ob.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk_10KHz);
        k++;
      end
      drain_en = 1'b1;
      ob.out_ready = 1'b1;
      wait_accepts(n, 40);
      compare_stream("rand");
    end
  endtask

  task automatic test_reset_mid_out();
    int k;
    fresh();
    drain_en = 1'b0;
    ob.out_ready = 1'b0;
    preload(1);
    drain_en = 1'b1;
    k = 0;
    while (!ob.out_valid && k < 20) begin
      @(negedge clk_10KHz);
      k++;
    end
    vectors++;
    if (!ob.out_valid) begin
      miscompares++;
      $display("FAIL rst_reach_out got=0 want=1");
    end
    hold_chk = 1'b0;
    #20 reset = 1'b1;
    #1;
    vectors++;
    if ({ob.out_valid, deq, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_async got=%b want=000",
               {ob.out_valid, deq, busy});
    end
    vectors++;
    if (ob.out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async_data got=%h want=00", ob.out_data);
    end
`ifdef FILA_READER_COUNT_EN
    vectors++;
    if (cnt !== '0) begin
      miscompares++;
      $display("FAIL rst_async_count got=%0d want=0", cnt);
    end
`endif
    @(negedge clk_10KHz);
    reset = 1'b0;
    drain_en = 1'b0;
    repeat (2) @(negedge clk_10KHz);
    pv = 1'b0;
    hold_chk = 1'b1;
  endtask

  task automatic test_invariants();
    vectors++;
    if (b2b_err != 0) begin
      miscompares++;
      $display("FAIL deq_b2b got=%0d want=0", b2b_err);
    end
    vectors++;
    if (deq_empty_err != 0) begin
      miscompares++;
      $display("FAIL deq_empty got=%0d want=0", deq_empty_err);
    end
    vectors++;
    if (deq_enq_err != 0) begin
      miscompares++;
      $display("FAIL deq_enq got=%0d want=0", deq_enq_err);
    end
    vectors++;
    if (hold_err != 0) begin
      miscompares++;
      $display("FAIL out_hold got=%0d want=0", hold_err);
    end
  endtask

  initial begin
    ob.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_enq_collision();
    test_flush();
    test_back_to_back();
    test_reset_mid_out();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
